// File: rtl/coprosit_pkg.sv
`default_nettype none
// ============================================================================
// coprosit_pkg : writeback tag types shared by execute and writeback stages
// Rev 1.0
// ============================================================================
package coprosit_pkg;
   localparam int ID_WIDTH = 4;

   typedef enum logic [1:0] {
      DST_NONE = 2'd0,
      DST_PRF  = 2'd1,
      DST_XRF  = 2'd2
   } wb_dst_e;

   typedef struct packed {
      logic [ID_WIDTH-1:0] id;
      logic [4:0]          rd;
      wb_dst_e             dst;
   } wb_tag_t;

   // Encoding 3 is not listed, so it falls out as DST_NONE (neither helper true)
   function automatic logic dst_is_prf(input wb_dst_e d);
      return d == DST_PRF;
   endfunction

   function automatic logic dst_is_xrf(input wb_dst_e d);
      return d == DST_XRF;
   endfunction
endpackage
`default_nettype wire

// File: rtl/prau_pkg.sv
`default_nettype none
// ============================================================================
// prau_pkg : posit arithmetic unit shared constants (posit word width)
// Rev 1.0
// ============================================================================
package prau_pkg;
   localparam int POSLEN = 32;
endpackage
`default_nettype wire

// File: rtl/coprosit_wb_fifo.sv
`default_nettype none
// ============================================================================
// coprosit_wb_fifo : in-order DEPTH x WIDTH FIFO, count-based full/empty
// Rev 1.0
// ============================================================================
module coprosit_wb_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push, pop;

   assign full_o  = (count_q == CNT_DEPTH);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   assign push = push_i & ~full_o;
   assign pop  = pop_i & ~empty_o;

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      count_d  = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is intentionally unreset; validity is tracked solely by count_q
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= wdata_i;
   end
endmodule
`default_nettype wire

// File: rtl/coprosit_wb_stage.sv
`default_nettype none
// ============================================================================
// coprosit_wb_stage : buffers execute results and retires them in order to
// the posit register file, the core result port, or drops tagless entries
// Rev 1.0
// ============================================================================
module coprosit_wb_stage
   import coprosit_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int DEPTH = 2
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        in_valid_i,
   output logic                        in_ready_o,
   input  wb_tag_t                     in_tag_i,
   input  logic [XLEN-1:0]             in_result_i,
   output logic                        prf_we_o,
   output logic [4:0]                  prf_waddr_o,
   output logic [prau_pkg::POSLEN-1:0] prf_wdata_o,
   output logic                        res_valid_o,
   input  logic                        res_ready_i,
   output logic [ID_WIDTH-1:0]         res_id_o,
   output logic [4:0]                  res_rd_o,
   output logic [XLEN-1:0]             res_data_o,
   output logic [$clog2(DEPTH):0]      count_o
);
   localparam int ENTRY_W = $bits(wb_tag_t) + XLEN;

   logic [ENTRY_W-1:0] head;
   wb_tag_t            head_tag;
   logic [XLEN-1:0]    head_result;
   logic               full, empty, pop;
   logic               head_prf, head_xrf;

   coprosit_wb_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (in_valid_i),
      .wdata_i ({in_tag_i, in_result_i}),
      .pop_i   (pop),
      .rdata_o (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (count_o)
   );

   assign head_tag    = head[ENTRY_W-1:XLEN];
   assign head_result = head[XLEN-1:0];
   assign in_ready_o  = ~full;

   // XRF head waits on the core; PRF and tagless heads leave unconditionally
   always_comb begin
      head_prf    = dst_is_prf(head_tag.dst);
      head_xrf    = dst_is_xrf(head_tag.dst);
      prf_we_o    = ~empty & head_prf;
      res_valid_o = ~empty & head_xrf;
      pop         = ~empty & (~head_xrf | res_ready_i);
   end

   assign prf_waddr_o = head_tag.rd;
   assign prf_wdata_o = head_result[prau_pkg::POSLEN-1:0];
   assign res_id_o    = head_tag.id;
   assign res_rd_o    = head_tag.rd;
   assign res_data_o  = head_result;
endmodule
`default_nettype wire

// File: tb/tb_coprosit_wb_stage.sv
`default_nettype none
// ============================================================================
// tb_coprosit_wb_stage : directed self-checking bench for the writeback stage
// Rev 1.0
// ============================================================================
module tb_coprosit_wb_stage;
   import coprosit_pkg::*;

   localparam int XLEN  = 64;
   localparam int DEPTH = 2;

   logic              clk_i = 1'b0;
   logic              rst_ni = 1'b0;
   logic              in_valid_i = 1'b0;
   logic              in_ready_o;
   wb_tag_t           in_tag_i;
   logic [XLEN-1:0]   in_result_i = '0;
   logic              prf_we_o;
   logic [4:0]        prf_waddr_o;
   logic [31:0]       prf_wdata_o;
   logic              res_valid_o;
   logic              res_ready_i = 1'b0;
   logic [3:0]        res_id_o;
   logic [4:0]        res_rd_o;
   logic [XLEN-1:0]   res_data_o;
   logic [1:0]        count_o;

   int n_tests = 0;
   int n_fail  = 0;

   coprosit_wb_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .in_tag_i    (in_tag_i),
      .in_result_i (in_result_i),
      .prf_we_o    (prf_we_o),
      .prf_waddr_o (prf_waddr_o),
      .prf_wdata_o (prf_wdata_o),
      .res_valid_o (res_valid_o),
      .res_ready_i (res_ready_i),
      .res_id_o    (res_id_o),
      .res_rd_o    (res_rd_o),
      .res_data_o  (res_data_o),
      .count_o     (count_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] id, input logic [4:0] rd,
                        input logic [1:0] dst, input logic [XLEN-1:0] data);
      in_valid_i  = v;
      in_tag_i.id  = id;
      in_tag_i.rd  = rd;
      in_tag_i.dst = wb_dst_e'(dst);
      in_result_i = data;
   endtask

   task automatic test_reset();
      drive(1'b0, 4'd0, 5'd0, 2'd0, '0);
      #2;
      n_tests++;
      if ({in_ready_o, prf_we_o, res_valid_o, count_o} !== {1'b1, 1'b0, 1'b0, 2'd0}) begin
         n_fail++;
         $display("FAIL reset_values: got rdy/we/val/cnt=%b%b%b%0d want 1000",
                  in_ready_o, prf_we_o, res_valid_o, count_o);
      end
      @(negedge clk_i);
      rst_ni = 1'b1;
      tick();
   endtask

   task automatic test_prf();
      drive(1'b1, 4'd1, 5'd3, 2'd1, 64'h0000_0000_4000_0000);
      tick();
      drive(1'b0, 4'd0, 5'd0, 2'd0, '0);
      #1;
      n_tests++;
      if ({prf_we_o, prf_waddr_o, prf_wdata_o, res_valid_o, count_o} !==
          {1'b1, 5'd3, 32'h4000_0000, 1'b0, 2'd1}) begin
         n_fail++;
         $display("FAIL prf_write: got we=%b wa=%0d wd=%h val=%b cnt=%0d want 1/3/40000000/0/1",
                  prf_we_o, prf_waddr_o, prf_wdata_o, res_valid_o, count_o);
      end
      tick();
      n_tests++;
      if ({prf_we_o, count_o} !== {1'b0, 2'd0}) begin
         n_fail++;
         $display("FAIL prf_single_pulse: got we=%b cnt=%0d want 0/0", prf_we_o, count_o);
      end
   endtask

   task automatic test_xrf_backpressure();
      res_ready_i = 1'b0;
      drive(1'b1, 4'd2, 5'd10, 2'd2, 64'd1);
      tick();
      drive(1'b0, 4'd0, 5'd0, 2'd0, '0);
      for (int i = 0; i < 5; i++) begin
         #1;
         n_tests++;
         if ({res_valid_o, res_id_o, res_rd_o, res_data_o, prf_we_o} !==
             {1'b1, 4'd2, 5'd10, 64'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL xrf_hold[%0d]: got val=%b id=%0d rd=%0d data=%h we=%b want 1/2/10/1/0",
                     i, res_valid_o, res_id_o, res_rd_o, res_data_o, prf_we_o);
         end
         tick();
      end
      res_ready_i = 1'b1;
      tick();
      res_ready_i = 1'b0;
      #1;
      n_tests++;
      if ({res_valid_o, count_o} !== {1'b0, 2'd0}) begin
         n_fail++;
         $display("FAIL xrf_pop: got val=%b cnt=%0d want 0/0", res_valid_o, count_o);
      end
   endtask

   task automatic test_full_stall();
      res_ready_i = 1'b0;
      drive(1'b1, 4'd3, 5'd4, 2'd2, 64'hA);
      tick();
      drive(1'b1, 4'd4, 5'd5, 2'd2, 64'hB);
      tick();
      drive(1'b1, 4'd5, 5'd6, 2'd1, 64'hC);
      #1;
      n_tests++;
      if ({count_o, in_ready_o} !== {2'd2, 1'b0}) begin
         n_fail++;
         $display("FAIL full_flags: got cnt=%0d rdy=%b want 2/0", count_o, in_ready_o);
      end
      tick();
      drive(1'b0, 4'd0, 5'd0, 2'd0, '0);
      n_tests++;
      if ({count_o, res_id_o, res_data_o} !== {2'd2, 4'd3, 64'hA}) begin
         n_fail++;
         $display("FAIL full_reject: got cnt=%0d id=%0d data=%h want 2/3/a",
                  count_o, res_id_o, res_data_o);
      end
      res_ready_i = 1'b1;
      tick();
      res_ready_i = 1'b0;
      #1;
      n_tests++;
      if ({in_ready_o, count_o, res_valid_o, res_id_o, res_rd_o, res_data_o} !==
          {1'b1, 2'd1, 1'b1, 4'd4, 5'd5, 64'hB}) begin
         n_fail++;
         $display("FAIL full_order: got rdy=%b cnt=%0d val=%b id=%0d rd=%0d data=%h want 1/1/1/4/5/b",
                  in_ready_o, count_o, res_valid_o, res_id_o, res_rd_o, res_data_o);
      end
      res_ready_i = 1'b1;
      tick();
      res_ready_i = 1'b0;
      n_tests++;
      if ({count_o, prf_we_o} !== {2'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL full_drain: got cnt=%0d we=%b want 0/0 (third push must be dropped)",
                  count_o, prf_we_o);
      end
   endtask

   task automatic test_in_order();
      res_ready_i = 1'b0;
      drive(1'b1, 4'd6, 5'd7, 2'd2, 64'h77);
      tick();
      drive(1'b1, 4'd7, 5'd8, 2'd1, 64'h88);
      tick();
      drive(1'b0, 4'd0, 5'd0, 2'd0, '0);
      for (int i = 0; i < 3; i++) begin
         n_tests++;
         if ({prf_we_o, res_valid_o, res_id_o} !== {1'b0, 1'b1, 4'd6}) begin
            n_fail++;
            $display("FAIL inorder_block[%0d]: got we=%b val=%b id=%0d want 0/1/6",
                     i, prf_we_o, res_valid_o, res_id_o);
         end
         tick();
      end
      res_ready_i = 1'b1;
      tick();
      res_ready_i = 1'b0;
      #1;
      n_tests++;
      if ({prf_we_o, prf_waddr_o, prf_wdata_o, res_valid_o} !== {1'b1, 5'd8, 32'h88, 1'b0}) begin
         n_fail++;
         $display("FAIL inorder_release: got we=%b wa=%0d wd=%h val=%b want 1/8/88/0",
                  prf_we_o, prf_waddr_o, prf_wdata_o, res_valid_o);
      end
      tick();
      n_tests++;
      if ({prf_we_o, count_o} !== {1'b0, 2'd0}) begin
         n_fail++;
         $display("FAIL inorder_drain: got we=%b cnt=%0d want 0/0", prf_we_o, count_o);
      end
   endtask

   task automatic test_streaming();
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 4'(i), 5'(16 + i), 2'd1, 64'h100 + 64'(i));
         #1;
         n_tests++;
         if (!in_ready_o) begin
            n_fail++;
            $display("FAIL stream_ready[%0d]: got rdy=%b want 1", i, in_ready_o);
         end
         if (i > 0) begin
            n_tests++;
            if ({prf_we_o, prf_waddr_o, prf_wdata_o, count_o} !==
                {1'b1, 5'(16 + i - 1), 32'h100 + 32'(i - 1), 2'd1}) begin
               n_fail++;
               $display("FAIL stream_write[%0d]: got we=%b wa=%0d wd=%h cnt=%0d want 1/%0d/%h/1",
                        i, prf_we_o, prf_waddr_o, prf_wdata_o, count_o,
                        16 + i - 1, 32'h100 + 32'(i - 1));
            end
         end
         tick();
      end
      drive(1'b0, 4'd0, 5'd0, 2'd0, '0);
      #1;
      n_tests++;
      if ({prf_we_o, prf_waddr_o, prf_wdata_o} !== {1'b1, 5'd23, 32'h107}) begin
         n_fail++;
         $display("FAIL stream_last: got we=%b wa=%0d wd=%h want 1/23/107",
                  prf_we_o, prf_waddr_o, prf_wdata_o);
      end
      tick();
      n_tests++;
      if ({prf_we_o, count_o} !== {1'b0, 2'd0}) begin
         n_fail++;
         $display("FAIL stream_drain: got we=%b cnt=%0d want 0/0", prf_we_o, count_o);
      end
   endtask

   task automatic test_none_and_idle();
      res_ready_i = 1'b1;
      drive(1'b1, 4'd8, 5'd9, 2'd0, 64'h55);
      tick();
      drive(1'b1, 4'd9, 5'd10, 2'd3, 64'h66);
      #1;
      n_tests++;
      if ({prf_we_o, res_valid_o, count_o} !== {1'b0, 1'b0, 2'd1}) begin
         n_fail++;
         $display("FAIL dst_none: got we=%b val=%b cnt=%0d want 0/0/1",
                  prf_we_o, res_valid_o, count_o);
      end
      tick();
      drive(1'b0, 4'd0, 5'd0, 2'd0, '0);
      #1;
      n_tests++;
      if ({prf_we_o, res_valid_o, count_o} !== {1'b0, 1'b0, 2'd1}) begin
         n_fail++;
         $display("FAIL dst_three: got we=%b val=%b cnt=%0d want 0/0/1",
                  prf_we_o, res_valid_o, count_o);
      end
      tick();
      n_tests++;
      if ({prf_we_o, res_valid_o, count_o} !== {1'b0, 1'b0, 2'd0}) begin
         n_fail++;
         $display("FAIL idle_ready: got we=%b val=%b cnt=%0d want 0/0/0",
                  prf_we_o, res_valid_o, count_o);
      end
      res_ready_i = 1'b0;
   endtask

   task automatic test_reset_mid();
      res_ready_i = 1'b0;
      drive(1'b1, 4'd10, 5'd11, 2'd2, 64'h99);
      tick();
      drive(1'b1, 4'd11, 5'd12, 2'd1, 64'hAA);
      tick();
      drive(1'b0, 4'd0, 5'd0, 2'd0, '0);
      #2;
      rst_ni = 1'b0;
      #1;
      n_tests++;
      if ({in_ready_o, prf_we_o, res_valid_o, count_o} !== {1'b1, 1'b0, 1'b0, 2'd0}) begin
         n_fail++;
         $display("FAIL reset_async: got rdy/we/val/cnt=%b%b%b%0d want 1000",
                  in_ready_o, prf_we_o, res_valid_o, count_o);
      end
      tick();
      @(negedge clk_i);
      rst_ni = 1'b1;
      res_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++;
         if ({prf_we_o, res_valid_o, count_o} !== {1'b0, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_after[%0d]: got we=%b val=%b cnt=%0d want 0/0/0",
                     i, prf_we_o, res_valid_o, count_o);
         end
      end
      res_ready_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_prf();
      test_xrf_backpressure();
      test_full_stall();
      test_in_order();
      test_streaming();
      test_none_and_idle();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
